// File: rtl/div_result_bcd.sv
// div_result_bcd: converts the signed quotient/remainder of divider_8bit into
// sign + packed-BCD magnitude using an iterative double-dabble datapath.
// Handshake: valid/ready on both sides; one conversion takes WIDTH cycles.
// Optional feature macro: DIV_BCD_REM_CONVERT_EN
//   defined   -> remainder is converted alongside the quotient
//   undefined -> remainder datapath absent, o_rem_neg/o_rem_bcd tied to 0
module div_result_bcd #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTH-1:0]    i_quo,
    input  logic [WIDTH-1:0]    i_rem,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_quo_neg,
    output logic [4*NDIG-1:0]   o_quo_bcd,
    output logic                o_rem_neg,
    output logic [4*NDIG-1:0]   o_rem_bcd
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Two's-complement magnitude computed unsigned, so the most negative
    // value maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return (~v) + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // next magnitude bit in at the bottom.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             msb);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < NDIG; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                adj[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return (adj << 1) | {{(BCD_W-1){1'b0}}, msb};
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ready_r;
    logic               valid_r;
    logic               capture_s;
    logic               last_iter_s;

    logic               quo_neg_r;
    logic [WIDTH-1:0]   quo_mag_r;
    logic [BCD_W-1:0]   quo_acc_r;
    logic [BCD_W-1:0]   quo_acc_nxt_s;
    logic               quo_neg_out_r;
    logic [BCD_W-1:0]   quo_bcd_out_r;

    assign capture_s     = i_valid && ready_r;
    assign last_iter_s   = (state_r == ST_CONV) && (cnt_r == LAST_ITER);
    assign quo_acc_nxt_s = bcd_step(quo_acc_r, quo_mag_r[WIDTH-1]);

    assign o_ready   = ready_r;
    assign o_valid   = valid_r;
    assign o_quo_neg = quo_neg_out_r;
    assign o_quo_bcd = quo_bcd_out_r;

    // Next-state decode for the IDLE/CONV/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_r == LAST_ITER) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Iteration counter: cleared at capture, counts WIDTH shift steps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_CONV) begin
            cnt_r <= (cnt_r == LAST_ITER) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Quotient working registers: load at capture, shift-add-3 during CONV.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_neg_r <= 1'b0;
            quo_mag_r <= {WIDTH{1'b0}};
            quo_acc_r <= {BCD_W{1'b0}};
        end else if (capture_s) begin
            quo_neg_r <= i_quo[WIDTH-1];
            quo_mag_r <= abs_mag(i_quo);
            quo_acc_r <= {BCD_W{1'b0}};
        end else if (state_r == ST_CONV) begin
            quo_neg_r <= quo_neg_r;
            quo_mag_r <= quo_mag_r << 1;
            quo_acc_r <= quo_acc_nxt_s;
        end else begin
            quo_neg_r <= quo_neg_r;
            quo_mag_r <= quo_mag_r;
            quo_acc_r <= quo_acc_r;
        end
    end

    // Quotient result registers: written only on the edge that enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_neg_out_r <= 1'b0;
            quo_bcd_out_r <= {BCD_W{1'b0}};
        end else if (last_iter_s) begin
            quo_neg_out_r <= quo_neg_r;
            quo_bcd_out_r <= quo_acc_nxt_s;
        end else begin
            quo_neg_out_r <= quo_neg_out_r;
            quo_bcd_out_r <= quo_bcd_out_r;
        end
    end

`ifdef DIV_BCD_REM_CONVERT_EN
    logic               rem_neg_r;
    logic [WIDTH-1:0]   rem_mag_r;
    logic [BCD_W-1:0]   rem_acc_r;
    logic [BCD_W-1:0]   rem_acc_nxt_s;
    logic               rem_neg_out_r;
    logic [BCD_W-1:0]   rem_bcd_out_r;

    assign rem_acc_nxt_s = bcd_step(rem_acc_r, rem_mag_r[WIDTH-1]);
    assign o_rem_neg     = rem_neg_out_r;
    assign o_rem_bcd     = rem_bcd_out_r;

    // Remainder working registers, running in lockstep with the quotient.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_neg_r <= 1'b0;
            rem_mag_r <= {WIDTH{1'b0}};
            rem_acc_r <= {BCD_W{1'b0}};
        end else if (capture_s) begin
            rem_neg_r <= i_rem[WIDTH-1];
            rem_mag_r <= abs_mag(i_rem);
            rem_acc_r <= {BCD_W{1'b0}};
        end else if (state_r == ST_CONV) begin
            rem_neg_r <= rem_neg_r;
            rem_mag_r <= rem_mag_r << 1;
            rem_acc_r <= rem_acc_nxt_s;
        end else begin
            rem_neg_r <= rem_neg_r;
            rem_mag_r <= rem_mag_r;
            rem_acc_r <= rem_acc_r;
        end
    end

    // Remainder result registers: written only on the edge that enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_neg_out_r <= 1'b0;
            rem_bcd_out_r <= {BCD_W{1'b0}};
        end else if (last_iter_s) begin
            rem_neg_out_r <= rem_neg_r;
            rem_bcd_out_r <= rem_acc_nxt_s;
        end else begin
            rem_neg_out_r <= rem_neg_out_r;
            rem_bcd_out_r <= rem_bcd_out_r;
        end
    end
`else
    // Remainder conversion disabled: outputs are constant zero, input ignored.
    logic unused_rem_s;
    assign unused_rem_s = ^i_rem;
    assign o_rem_neg    = 1'b0;
    assign o_rem_bcd    = {BCD_W{1'b0}};
`endif

endmodule
